uart_tx: RTL and testbench

//  Serial UART transmitter: takes a parallel byte over valid/ready and shifts it out on tx.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_bit_timer.sv | 29 ++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, idle line level
// and a frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Frame length in tick pulses for a given frame shape.
  function automatic int frame_ticks(input int data_bits, input int stop_bits,
                                     input int parity_bits, input int oversample);
    return (1 + data_bits + parity_bits + stop_bits) * oversample;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-side valid/ready byte handshake into the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Sub-bit counter: counts baud ticks and flags the tick that ends each serial bit.
module uart_tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic bit_end
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] count;

  // Clear wins over tick, so a tick landing on the accept edge is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_end = tick && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and shifts it out LSB first.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx: OVERSAMPLE must be at least 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [BW-1:0]        bit_idx;
  logic                 ready_q;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic [DATA_BITS-1:0] payload;
`endif

  uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .tick    (tick),
    .bit_end (bit_end)
  );

  assign bus.ready = ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= TX_IDLE_LEVEL;
      ready_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      payload <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid && ready_q) begin
            shift   <= bus.data_in;
`ifdef UART_TX_PARITY_EN
            payload <= bus.data_in;
`endif
            state   <= START;
            tx      <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              tx      <= (^payload) ^ 1'(PARITY_ODD);
`else
              state   <= STOP;
              tx      <= TX_IDLE_LEVEL;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // Next bit is what will sit in shift[0] after this shift.
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_idx <= '0;
            tx      <= TX_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            if (bit_idx == BW'(STOP_BITS - 1)) begin
              state   <= IDLE;
              done    <= 1'b1;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= TX_IDLE_LEVEL;
          ready_q <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (1 stop bit, 2 stop bits, odd parity), tick every 4 clk,
// frames checked against a bit-list model sampled at bit centres and bit ends.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  int         tick_ph = 0;
  logic [7:0] data_r  [3];
  logic       valid_r [3];
  logic       ready_w [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       done_w  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_ph = (tick_ph + 1) % 4;
    tick = (tick_ph == 0);
  end

  uart_tx_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_if #(.DATA_BITS(8)) bus2 ();

  assign bus0.data_in = data_r[0];
  assign bus0.valid   = valid_r[0];
  assign ready_w[0]   = bus0.ready;
  assign bus1.data_in = data_r[1];
  assign bus1.valid   = valid_r[1];
  assign ready_w[1]   = bus1.ready;
  assign bus2.data_in = data_r[2];
  assign bus2.valid   = valid_r[2];
  assign ready_w[2]   = bus2.ready;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus0),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .OVERSAMPLE(16), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus1),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .bus(bus2),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  // Reference: the frame as an ordered list of line levels, one per serial bit.
  function automatic void model_frame(input logic [7:0] d, input int stop_bits, input int odd,
                                      output logic [15:0] bits, output int nbits);
    int ones;
    bits = '1;
    nbits = 0;
    ones = 0;
    bits[nbits] = 1'b0;
    nbits++;
    for (int i = 0; i < 8; i++) begin
      bits[nbits] = d[i];
      if (d[i]) ones++;
      nbits++;
    end
    if (PAR == 1) begin
      bits[nbits] = ((ones + odd) % 2 == 1);
      nbits++;
    end
    for (int s = 0; s < stop_bits; s++) begin
      bits[nbits] = 1'b1;
      nbits++;
    end
  endfunction

  // Waits for the accept, then counts ticks after it, recording tx at the centre and the last
  // tick of every bit, plus every done pulse. Called and left at 1 time unit after a rising edge.
  task automatic capture(input int idx, input int nbits, input bit hold, input logic [7:0] next_data,
                         output logic [15:0] mid, output logic [15:0] late,
                         output int done_n, output int done_cnt, output time acc_t, output time done_t,
                         output logic tick_acc, output logic tx_start, output logic busy_mid,
                         output bit to);
    int n;
    int guard;
    mid = '1; late = '1; done_n = -1; done_cnt = 0; acc_t = 0; done_t = 0;
    tick_acc = 1'b0; tx_start = 1'b1; busy_mid = 1'b0; to = 1'b0;
    guard = 0;
    while (!(ready_w[idx] === 1'b1 && valid_r[idx] === 1'b1)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 1000) begin
        to = 1'b1;
        return;
      end
    end
    @(posedge clk);
    acc_t = $time;
    #1;
    tick_acc = tick;
    tx_start = tx_w[idx];
    data_r[idx] = next_data;
    if (!hold) valid_r[idx] = 1'b0;
    n = 0;
    guard = 0;
    while (n < nbits * 16) begin
      @(posedge clk); #1;
      guard++;
      if (guard > nbits * 16 * 4 + 100) begin
        to = 1'b1;
        return;
      end
      if (tick) begin
        n++;
        if (n % 16 == 8)  mid[n / 16]  = tx_w[idx];
        if (n % 16 == 15) late[n / 16] = tx_w[idx];
        if (n == nbits * 8) busy_mid = busy_w[idx];
      end
      if (done_w[idx]) begin
        done_cnt++;
        done_n = n;
        done_t = $time - 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_r[i] = 1'b0;
      data_r[i]  = 8'h00;
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_w[0] !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b want 1", tx_w[0]); end
    checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_w[0]); end
    checks++; if (busy_w[0] !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy_w[0]); end
    checks++; if (done_w[0] !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done_w[0]); end
    checks++; if (tx_w[1] !== 1'b1 || tx_w[2] !== 1'b1) begin errors++; $display("FAIL reset_tx_others: got %b%b want 11", tx_w[1], tx_w[2]); end
  endtask

  task automatic test_single_55();
    logic [15:0] exp, mid, late;
    int nb, dn, dc;
    time at, dt;
    logic ta, ts, bm;
    bit to;
    model_frame(8'h55, 1, 0, exp, nb);
    data_r[0] = 8'h55;
    valid_r[0] = 1'b1;
    capture(0, nb, 1'b0, 8'($urandom), mid, late, dn, dc, at, dt, ta, ts, bm, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL s55_timeout: got %b want 0", to); end
    checks++; if (ts !== 1'b0) begin errors++; $display("FAIL s55_start_edge: tx %b want 0", ts); end
    checks++; if (mid !== exp) begin errors++; $display("FAIL s55_centres: got %h want %h", mid, exp); end
    checks++; if (late !== exp) begin errors++; $display("FAIL s55_bit_ends: got %h want %h", late, exp); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL s55_done_count: got %0d want 1", dc); end
    checks++; if (dn !== nb * 16) begin errors++; $display("FAIL s55_done_tick: got %0d want %0d", dn, nb * 16); end
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL s55_busy_mid: got %b want 1", bm); end
    @(posedge clk); #1;
    checks++; if (ready_w[0] !== 1'b1) begin errors++; $display("FAIL s55_ready_after: got %b want 1", ready_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL s55_done_width: got %b want 0", done_w[0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2, mid1, mid2, late1, late2;
    int nb1, nb2, dn1, dn2, dc1, dc2;
    time at1, at2, dt1, dt2;
    logic ta, ts1, ts2, bm;
    bit to1, to2;
    model_frame(8'hA3, 1, 0, exp1, nb1);
    model_frame(8'h0F, 1, 0, exp2, nb2);
    data_r[0] = 8'hA3;
    valid_r[0] = 1'b1;
    capture(0, nb1, 1'b1, 8'h0F, mid1, late1, dn1, dc1, at1, dt1, ta, ts1, bm, to1);
    capture(0, nb2, 1'b0, 8'($urandom), mid2, late2, dn2, dc2, at2, dt2, ta, ts2, bm, to2);
    checks++; if (to1 !== 1'b0 || to2 !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got %b%b want 00", to1, to2); end
    checks++; if (mid1[8:1] !== 8'hA3) begin errors++; $display("FAIL b2b_byte1: got %h want a3", mid1[8:1]); end
    checks++; if (mid2[8:1] !== 8'h0F) begin errors++; $display("FAIL b2b_byte2: got %h want 0f", mid2[8:1]); end
    checks++; if (mid1 !== exp1 || mid2 !== exp2) begin errors++; $display("FAIL b2b_frames: got %h %h want %h %h", mid1, mid2, exp1, exp2); end
    checks++; if (at2 - dt1 !== 64'd10) begin errors++; $display("FAIL b2b_gap: got %0t want 10", at2 - dt1); end
    checks++; if (ts2 !== 1'b0) begin errors++; $display("FAIL b2b_start2: tx %b want 0", ts2); end
    checks++; if (dc1 !== 1 || dc2 !== 1) begin errors++; $display("FAIL b2b_done_count: got %0d %0d want 1 1", dc1, dc2); end
    checks++; if (dn2 !== nb2 * 16) begin errors++; $display("FAIL b2b_done_tick: got %0d want %0d", dn2, nb2 * 16); end
  endtask

  task automatic test_parity();
    logic [15:0] exp, mid, late;
    int nb, dn, dc;
    time at, dt;
    logic ta, ts, bm;
    bit to;
    for (int idx = 0; idx < 3; idx += 2) begin
      model_frame(8'h07, 1, (idx == 2) ? 1 : 0, exp, nb);
      data_r[idx] = 8'h07;
      valid_r[idx] = 1'b1;
      capture(idx, nb, 1'b0, 8'($urandom), mid, late, dn, dc, at, dt, ta, ts, bm, to);
      checks++; if (mid !== exp) begin errors++; $display("FAIL parity_frame_%0d: got %h want %h", idx, mid, exp); end
      checks++; if (dn !== nb * 16 || dc !== 1) begin errors++; $display("FAIL parity_len_%0d: done at %0d x%0d want %0d x1", idx, dn, dc, nb * 16); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp, mid, late;
    int nb, dn, dc, n, guard, dcnt;
    time at, dt;
    logic ta, ts, bm;
    bit to;
    data_r[0] = 8'hFF;
    valid_r[0] = 1'b1;
    guard = 0;
    while (ready_w[0] !== 1'b1 && guard < 1000) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    valid_r[0] = 1'b0;
    data_r[0] = 8'($urandom);
    n = 0;
    guard = 0;
    while (n < 3 * 16 + 8 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
      if (tick) n++;
    end
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy_w[0]); end
    rst = 1'b1;
    #1;
    checks++; if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: tx/ready/busy/done %b%b%b%b want 1100", tx_w[0], ready_w[0], busy_w[0], done_w[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dcnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) dcnt++;
    end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", dcnt); end
    model_frame(8'h01, 1, 0, exp, nb);
    data_r[0] = 8'h01;
    valid_r[0] = 1'b1;
    capture(0, nb, 1'b0, 8'($urandom), mid, late, dn, dc, at, dt, ta, ts, bm, to);
    checks++; if (mid !== exp || late !== exp) begin errors++; $display("FAIL rstmid_resend: got %h/%h want %h", mid, late, exp); end
    checks++; if (dn !== nb * 16 || dc !== 1) begin errors++; $display("FAIL rstmid_done: at %0d x%0d want %0d x1", dn, dc, nb * 16); end
  endtask

  task automatic test_two_stop();
    logic [15:0] exp, mid, late;
    int nb, dn, dc, guard;
    time at, dt;
    logic ta, ts, bm;
    bit to;
    model_frame(8'h00, 2, 0, exp, nb);
    guard = 0;
    do begin @(posedge clk); #1; guard++; end while (!tick && guard < 10);
    repeat (3) @(posedge clk);
    #1;
    data_r[1] = 8'h00;
    valid_r[1] = 1'b1;
    capture(1, nb, 1'b0, 8'($urandom), mid, late, dn, dc, at, dt, ta, ts, bm, to);
    checks++; if (ta !== 1'b1) begin errors++; $display("FAIL stop2_tick_on_accept: tick %b want 1", ta); end
    checks++; if (mid !== exp) begin errors++; $display("FAIL stop2_centres: got %h want %h", mid, exp); end
    checks++; if (late !== exp) begin errors++; $display("FAIL stop2_bit_ends: got %h want %h", late, exp); end
    checks++; if (dn !== nb * 16 || dc !== 1) begin errors++; $display("FAIL stop2_done: at %0d x%0d want %0d x1", dn, dc, nb * 16); end
  endtask

  task automatic test_random();
    logic [15:0] exp, mid, late;
    int nb, dn, dc, idx, gap;
    time at, dt;
    logic ta, ts, bm;
    bit to;
    logic [7:0] d;
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, 2);
      d = 8'($urandom);
      gap = $urandom_range(0, 20);
      repeat (gap) begin @(posedge clk); #1; end
      model_frame(d, (idx == 1) ? 2 : 1, (idx == 2) ? 1 : 0, exp, nb);
      data_r[idx] = d;
      valid_r[idx] = 1'b1;
      capture(idx, nb, 1'b0, 8'($urandom), mid, late, dn, dc, at, dt, ta, ts, bm, to);
      checks++; if (mid !== exp || late !== exp) begin errors++; $display("FAIL rand_frame dut%0d data %h: got %h/%h want %h", idx, d, mid, late, exp); end
      checks++; if (dn !== nb * 16 || dc !== 1) begin errors++; $display("FAIL rand_done dut%0d: at %0d x%0d want %0d x1", idx, dn, dc, nb * 16); end
    end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_parity();
    test_reset_midframe();
    test_two_stop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
